// File: rtl/flag_sequencer.sv
// Flag index controller for the VGA pride display. It synchronizes and debounces the
// four buttons, latches one command and applies it or an auto-advance step on frame_tick.
module flag_sequencer #(
    parameter int IDX_W       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_FRAMES  = 2,
    parameter int DWELL_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_clear,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               btn_load,
    input  logic [IDX_W-1:0]   load_value,
    input  logic [IDX_W-1:0]   max_index,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [IDX_W-1:0]   flag_index,
    output logic               index_changed,
    output logic               pending
);

    localparam int DEB_W = $clog2(DEB_FRAMES + 1);

    // Numeric order of the encoding is the priority order, so a plain >= compares priority.
    typedef enum logic [1:0] {
        CMD_PREV  = 2'd0,
        CMD_NEXT  = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [3:0]                  raw;
    logic [3:0][SYNC_STAGES-1:0] sync_q;
    logic [3:0]                  level;
    logic [3:0][DEB_W-1:0]       deb_q;
    logic [3:0]                  press;
    logic                        any_press;
    cmd_t                        new_cmd;
    cmd_t                        cmd_q;
    state_t                      state_q;
    state_t                      state_d;
    logic [DWELL_W-1:0]          dwell_q;
    logic [DWELL_W-1:0]          dwell_d;
    logic [DWELL_W-1:0]          dwell_last;
    logic                        apply;
    cmd_t                        apply_cmd;
    logic [IDX_W-1:0]            idx_next;

    // Bit position matches the cmd_t encoding.
    assign raw = {btn_clear, btn_load, btn_next, btn_prev};

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            level[b] = sync_q[b][SYNC_STAGES-1];
            press[b] = level[b] && frame_tick && (deb_q[b] == DEB_W'(DEB_FRAMES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            deb_q  <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
                sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
                if (!level[b]) begin
                    deb_q[b] <= '0;
                end else if (frame_tick && deb_q[b] != DEB_W'(DEB_FRAMES)) begin
                    deb_q[b] <= deb_q[b] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        any_press = |press;
        if (press[3])      new_cmd = CMD_CLEAR;
        else if (press[2]) new_cmd = CMD_LOAD;
        else if (press[1]) new_cmd = CMD_NEXT;
        else               new_cmd = CMD_PREV;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_press) state_d = ARMED;
            ARMED:   if (frame_tick && !any_press) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pending    = (state_q == ARMED);
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        apply     = 1'b0;
        apply_cmd = cmd_q;
        dwell_d   = auto_en ? dwell_q : '0;
        if (frame_tick) begin
            if (pending) begin
                apply   = 1'b1;
                dwell_d = '0;
            end else if (auto_en && dwell_q == dwell_last) begin
                apply     = 1'b1;
                apply_cmd = CMD_NEXT;
                dwell_d   = '0;
            end else if (auto_en) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // An index above max_index (after max_index shrank) is pulled back into range here.
    always_comb begin
        idx_next = '0;
        case (apply_cmd)
            CMD_NEXT:  idx_next = (flag_index < max_index) ? flag_index + IDX_W'(1) : '0;
            CMD_PREV:  idx_next = (flag_index == '0 || flag_index > max_index)
                                  ? max_index : flag_index - IDX_W'(1);
            CMD_LOAD:  idx_next = (load_value > max_index) ? max_index : load_value;
            CMD_CLEAR: idx_next = '0;
            default:   idx_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_q         <= CMD_PREV;
            dwell_q       <= '0;
            flag_index    <= '0;
            index_changed <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            index_changed <= apply;
            if (apply) flag_index <= idx_next;
            // The old command is consumed on frame_tick, so a simultaneous press always takes the slot.
            if (any_press && (!pending || frame_tick || new_cmd >= cmd_q)) cmd_q <= new_cmd;
        end
    end

endmodule
